// File: rtl/pio_seq_pkg.sv
// Shared definitions for the PIO pattern sequencer: FSM states, config map,
// step op codes and the PIO slave offsets the ops target.
package pio_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  localparam logic [3:0] REG_CTRL     = 4'd0;
  localparam logic [3:0] REG_INTERVAL = 4'd1;
  localparam logic [3:0] REG_LENGTH   = 4'd2;
  localparam logic [3:0] REG_STATUS   = 4'd3;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  localparam logic [2:0] PIO_DATA  = 3'd0;
  localparam logic [2:0] PIO_SET   = 3'd4;
  localparam logic [2:0] PIO_CLEAR = 3'd5;

  function automatic logic [2:0] opToPio(input logic [1:0] op);
    case (op)
      OP_SET:   return PIO_SET;
      OP_CLEAR: return PIO_CLEAR;
      default:  return PIO_DATA;
    endcase
  endfunction

endpackage

// File: rtl/pio_seq_timer.sv
// Loadable down-counter timing the gap between steps; expire flags the last
// waiting cycle so the next step issues on the following edge.
module pio_seq_timer #(
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_i,
  input  logic [IW-1:0] loadValue_i,
  input  logic          enable_i,
  output logic          expire_o
);

  logic [IW-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= loadValue_i;
    end else if (enable_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expire_o = enable_i && (count_q == IW'(1));

endmodule

// File: rtl/pio_pattern_seq.sv
// Plays a small table of PIO write/set/clear steps onto a PIO slave, spaced by
// a programmable interval, with optional looping and a done interrupt.
module pio_pattern_seq
  import pio_seq_pkg::*;
#(
  parameter int NSTEPS = 8,
  parameter int IW     = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  output logic        irq
);

  localparam int         IDXW   = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [2:0] MAXLEN = 3'(NSTEPS - 1);

  state_e        state_q, state_d;
  logic [2:0]    stepIdx_q, stepIdx_d;
  logic [2:0]    lenRun_q, lenRun_d;
  logic          done_q, done_d;
  logic          loop_q, irqEn_q;
  logic [IW-1:0] interval_q;
  logic [2:0]    length_q;
  logic [9:0]    pattern_q [NSTEPS];
  logic [2:0]    mAddr_q;
  logic [7:0]    mData_q;

  logic          wrEn, ctrlWr, statusWr, patWr, patRdSel;
  logic          startReq, stopReq, advance, lastStep, issuing, intervalShort, expire;
  logic [9:0]    curEntry;
  logic [1:0]    curOp;
  logic [2:0]    lengthIn;
  logic [IW-1:0] loadValue;
  logic          unusedWdata;

  assign wrEn     = s_chipselect && !s_write_n;
  assign ctrlWr   = wrEn && (s_address == REG_CTRL);
  assign statusWr = wrEn && (s_address == REG_STATUS);
  assign patRdSel = s_address[3] && (int'(s_address[2:0]) < NSTEPS);
  assign patWr    = wrEn && patRdSel;
  assign startReq = ctrlWr && s_writedata[0] && !s_writedata[1];
  assign stopReq  = ctrlWr && s_writedata[1];
  assign lengthIn = (int'(s_writedata[2:0]) >= NSTEPS) ? MAXLEN : s_writedata[2:0];
  assign unusedWdata = ^s_writedata;

  assign curEntry = pattern_q[stepIdx_q[IDXW-1:0]];
  assign curOp    = curEntry[9:8];
  assign issuing  = (state_q == ST_ISSUE) && (curOp != OP_NOP);

  // Intervals of 0 and 1 both mean the next step issues on the very next cycle.
  assign intervalShort = (interval_q <= IW'(1));
  assign loadValue     = intervalShort ? '0 : (interval_q - 1'b1);
  assign advance       = ((state_q == ST_ISSUE) && intervalShort) ||
                         ((state_q == ST_WAIT) && expire);
  assign lastStep      = (stepIdx_q == lenRun_q);

  pio_seq_timer #(.IW(IW)) timerInst (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (state_q == ST_ISSUE),
    .loadValue_i (loadValue),
    .enable_i    (state_q == ST_WAIT),
    .expire_o    (expire)
  );

  always_comb begin
    state_d   = state_q;
    stepIdx_d = stepIdx_q;
    lenRun_d  = lenRun_q;
    done_d    = done_q;
    if (statusWr && s_writedata[0]) begin
      done_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (startReq) begin
          state_d   = ST_ISSUE;
          stepIdx_d = '0;
          lenRun_d  = length_q;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        if (stopReq) begin
          state_d = ST_IDLE;
        end else if (advance) begin
          if (lastStep && !loop_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_ISSUE;
            stepIdx_d = lastStep ? 3'd0 : (stepIdx_q + 3'd1);
          end
        end else if (state_q == ST_ISSUE) begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      stepIdx_q <= '0;
      lenRun_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stepIdx_q <= stepIdx_d;
      lenRun_q  <= lenRun_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loop_q     <= 1'b0;
      irqEn_q    <= 1'b0;
      interval_q <= '0;
      length_q   <= '0;
      mAddr_q    <= '0;
      mData_q    <= '0;
      for (int i = 0; i < NSTEPS; i++) pattern_q[i] <= '0;
    end else begin
      if (ctrlWr) begin
        loop_q  <= s_writedata[2];
        irqEn_q <= s_writedata[3];
      end
      if (wrEn && (s_address == REG_INTERVAL)) interval_q <= s_writedata[IW-1:0];
      if (wrEn && (s_address == REG_LENGTH))   length_q   <= lengthIn;
      if (patWr) pattern_q[s_address[IDXW-1:0]] <= s_writedata[9:0];
      if (issuing) begin
        mAddr_q <= opToPio(curOp);
        mData_q <= curEntry[7:0];
      end
    end
  end

  // The strobe is driven straight from the ISSUE state so an async reset kills it at once.
  assign m_chipselect = issuing;
  assign m_write_n    = !issuing;
  assign m_address    = issuing ? opToPio(curOp) : mAddr_q;
  assign m_writedata  = {24'b0, (issuing ? curEntry[7:0] : mData_q)};
  assign irq          = done_q && irqEn_q;

  always_comb begin
    s_readdata = '0;
    case (s_address)
      REG_CTRL:     s_readdata = {28'b0, irqEn_q, loop_q, 1'b0, (state_q != ST_IDLE)};
      REG_INTERVAL: s_readdata[IW-1:0] = interval_q;
      REG_LENGTH:   s_readdata = {29'b0, length_q};
      REG_STATUS:   s_readdata = {31'b0, done_q};
      default: begin
        if (patRdSel) s_readdata = {22'b0, pattern_q[s_address[IDXW-1:0]]};
      end
    endcase
  end

endmodule

// File: doc/pio_pattern_seq.md
PIO_PATTERN_SEQ -- requirements
Module: pio_pattern_seq

Interface
REQ-001 SHALL have parameter NSTEPS, default 8, meaning pattern table depth; legal values are powers of two, at most 8.
REQ-002 SHALL have parameter IW, default 16, meaning interval counter width in bits.
REQ-003 SHALL have port clk, input, 1: clock; all logic is on the rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port s_address, input, 4: CPU config slave word address.
REQ-006 SHALL have port s_chipselect, input, 1: config slave select.
REQ-007 SHALL have port s_write_n, input, 1: config write strobe, active-low.
REQ-008 SHALL have port s_writedata, input, 32: config write data.
REQ-009 SHALL have port s_readdata, output, 32: config read data; combinational from s_address; zero-extended.
REQ-010 SHALL have port m_address, output, 3: PIO slave word address.
REQ-011 SHALL have port m_chipselect, output, 1: PIO slave select.
REQ-012 SHALL have port m_write_n, output, 1: PIO write strobe, active-low.
REQ-013 SHALL have port m_writedata, output, 32: PIO write data; bits 31:8 are always 0.
REQ-014 SHALL have port irq, output, 1: level interrupt, computed as done AND irq_en.

Function
REQ-015 Config register map:
- 0 CTRL: write bit0 start, bit1 stop, bit2 loop, bit3 irq_en; read bit0 busy, bit2 loop, bit3 irq_en.
- 1 INTERVAL: bits IW-1:0.
- 2 LENGTH: bits 2:0, giving LENGTH+1 steps; values at or above NSTEPS are clamped to NSTEPS-1.
- 3 STATUS: bit0 done, sticky; write 1 to clear.
- 8..8+NSTEPS-1 PATTERN[i]: bits 9:8 op, bits 7:0 data.
- All other addresses read 0 and ignore writes.
REQ-016 Step op encoding: 00 is a PIO write to address 0; 01 is a set, address 4; 10 is a clear, address 5; 11 is a no-op with no bus strobe but consumes its interval.
REQ-017 FSM states:
- IDLE: busy=0.
- ISSUE: exactly one cycle with m_chipselect=1, m_write_n=0, m_address per op, m_writedata={24'b0,data}.
- WAIT: counts the interval.
REQ-018 Outside ISSUE (or in ISSUE with a no-op), outputs SHALL be m_chipselect=0, m_write_n=1; m_address and m_writedata hold their last values.
REQ-019 A CTRL write with start=1 and stop=0 in IDLE at cycle N SHALL produce step 0 ISSUE at cycle N+1.
REQ-020 Step k+1 SHALL issue exactly max(INTERVAL,1) cycles after step k; INTERVAL=0 behaves as 1, giving back-to-back writes.
REQ-021 INTERVAL SHALL be sampled on entry to WAIT; changes mid-wait apply from the next step.
REQ-022 PATTERN entries SHALL be read at ISSUE time; rewriting an entry during a run takes effect on its next issue.
REQ-023 After the last step's interval expires:
- loop=1: next step is step 0, with no extra gap.
- loop=0: go to IDLE and set done in the same cycle.
REQ-024 Start while busy SHALL be ignored.
REQ-025 Stop SHALL win over start in the same write; the FSM enters IDLE on the next cycle, issues no further strobes, and leaves done unchanged.
REQ-026 If a stop write coincides with ISSUE, that in-flight strobe SHALL complete.
REQ-027 If a STATUS clear coincides with done being set, set SHALL win.
REQ-028 irq SHALL assert the cycle after done sets, provided irq_en=1.
REQ-029 The step index SHALL wrap modulo LENGTH+1, and LENGTH SHALL be sampled at start.

Reset
REQ-030 Assertion of reset_n SHALL force:
- the FSM to IDLE;
- all config registers, step index and counter to 0;
- m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, irq=0.
REQ-031 Reset asserted mid-run SHALL abort within the same cycle, with no strobe after assertion; deassertion SHALL not auto-restart.

Structure
REQ-032 Package pio_seq_pkg SHALL hold:
- the FSM state enum;
- config register offsets;
- op codes;
- PIO offsets (0 write, 4 set, 5 clear).
REQ-033 One sub-module, pio_seq_timer, SHALL hold the IW-bit loadable down-counter with load, enable and expire outputs.

Verification
REQ-034 Scenario 1:
- Stimulus: LENGTH=2, INTERVAL=4; PATTERN0=op00 data 0xA5, PATTERN1=op01 data 0x10, PATTERN2=op10 data 0x01; start at cycle N.
- Response: strobes at N+1 (addr 0, 0xA5), N+5 (addr 4, 0x10), N+9 (addr 5, 0x01); done at N+13; PIO model ends at 0xB4.
REQ-035 Scenario 2:
- Stimulus: INTERVAL=0, LENGTH=7, loop=1, run 20 cycles, then stop.
- Response: strobes on every cycle, addresses cycling through steps 0..7; no strobe after the stop cycle; done=0.
REQ-036 Scenario 3:
- Stimulus: PATTERN1=op11 within a 3-step run, INTERVAL=2.
- Response: no strobe at step 1's slot; step 2 issues 4 cycles after step 0.
REQ-037 Scenario 4:
- Stimulus: start while busy; then start+stop in one write.
- Response: first is ignored with timing unchanged; second causes IDLE the next cycle.
REQ-038 Scenario 5:
- Stimulus: irq_en=1, a run completes; write STATUS=1 in the same cycle done sets, then again later.
- Response: irq stays asserted after the first clear and drops the cycle after the second.
REQ-039 Scenario 6:
- Stimulus: reset_n low mid-WAIT.
- Response: all outputs go to reset values immediately; no strobe after release until a new start.
